// File: rtl/risc_phase_sequencer_if.sv
// risc_phase_sequencer_if: control/status bundle between the phase sequencer and the datapath.
interface risc_phase_sequencer_if #(parameter int OP_W = 3);
  logic en, zero, mem_ready, resume;
  logic [OP_W-1:0] opcode;
  logic [2:0] phase;
  logic sel, rd, ld_ir, inc_pc, ld_pc, data_e, ld_ac, wr, halt, mem_err, illegal;
  modport master (
    output en, opcode, zero, mem_ready, resume,
    input  phase, sel, rd, ld_ir, inc_pc, ld_pc, data_e, ld_ac, wr, halt, mem_err, illegal
  );
  modport slave (
    input  en, opcode, zero, mem_ready, resume,
    output phase, sel, rd, ld_ir, inc_pc, ld_pc, data_e, ld_ac, wr, halt, mem_err, illegal
  );
endinterface

// File: rtl/risc_phase_sequencer.sv
// risc_phase_sequencer: 8-phase CPU control unit with memory stall/timeout and halt/resume.
// Optional: CTRL_ILLEGAL_TRAP_EN traps opcodes >= 8 at p4 instead of running them as NOP.
module risc_phase_sequencer #(
  parameter int OP_W = 3,
  parameter int TO_W = 4
) (
  input logic clk,
  input logic rst_n,
  risc_phase_sequencer_if.slave bus
);
  typedef enum logic {RUN, HALTED} state_t;
  localparam logic [TO_W-1:0] LAST = {{(TO_W-1){1'b1}}, 1'b0};
  state_t state, state_n;
  logic [2:0] phase_q, phase_n;
  logic [OP_W-1:0] op_q, op_n;
  logic [TO_W-1:0] stall_cnt, stall_n;
  logic zero_q, zero_n, err_q, err_n, ill_q, ill_n;
  logic run, legal, alu, is_hlt, is_skz, is_jmp, is_sto, trap;
  logic [2:0] op3;
  assign op3 = op_q[2:0];
  assign legal = ~|(op_q >> 3);
  assign run = state == RUN;
  assign alu = legal && op3 >= 3'd2 && op3 <= 3'd5;
  assign is_hlt = legal && op3 == 3'd0;
  assign is_skz = legal && op3 == 3'd1;
  assign is_sto = legal && op3 == 3'd6;
  assign is_jmp = legal && op3 == 3'd7;
`ifdef CTRL_ILLEGAL_TRAP_EN
  assign trap = ~legal;
`else
  assign trap = 1'b0;
`endif
  assign bus.phase = phase_q;
  assign bus.halt = !run;
  assign bus.mem_err = err_q;
  assign bus.illegal = ill_q;
  assign bus.sel = run && !phase_q[2];
  assign bus.rd = run && ((phase_q != 3'd0 && !phase_q[2]) || (phase_q >= 3'd5 && alu));
  assign bus.ld_ir = run && phase_q[2:1] == 2'b01;
  assign bus.inc_pc = run && ((phase_q == 3'd4 && !is_hlt && !trap) || (phase_q == 3'd6 && is_skz && zero_q));
  assign bus.ld_pc = run && phase_q[2:1] == 2'b11 && is_jmp;
  assign bus.data_e = run && phase_q[2:1] == 2'b11 && is_sto;
  assign bus.ld_ac = run && phase_q == 3'd7 && alu;
  assign bus.wr = run && phase_q == 3'd7 && is_sto;
  always_comb begin
    state_n = state;
    phase_n = phase_q;
    op_n = op_q;
    zero_n = zero_q;
    stall_n = stall_cnt;
    err_n = err_q;
    ill_n = ill_q;
    if (!run) begin
      if (bus.resume) begin
        state_n = RUN;
        phase_n = err_q ? 3'd0 : 3'd5;
        err_n = 1'b0;
        ill_n = 1'b0;
      end
    end else if (bus.en) begin
      if (phase_q == 3'd4 && (is_hlt || trap)) begin
        state_n = HALTED;
        ill_n = trap;
      end else if (!(bus.rd || bus.wr) || bus.mem_ready) begin
        phase_n = phase_q + 3'd1;
        stall_n = '0;
        op_n = phase_q == 3'd3 ? bus.opcode : op_q;
        zero_n = phase_q == 3'd5 ? bus.zero : zero_q;
      end else if (stall_cnt == LAST) begin
        state_n = HALTED;
        err_n = 1'b1;
        stall_n = '0;
      end else begin
        stall_n = stall_cnt + 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      phase_q <= '0;
      op_q <= '0;
      zero_q <= 1'b0;
      stall_cnt <= '0;
      err_q <= 1'b0;
      ill_q <= 1'b0;
    end else begin
      state <= state_n;
      phase_q <= phase_n;
      op_q <= op_n;
      zero_q <= zero_n;
      stall_cnt <= stall_n;
      err_q <= err_n;
      ill_q <= ill_n;
    end
  end
endmodule

// File: tb/tb_risc_phase_sequencer.sv
// tb_risc_phase_sequencer: directed and random checks against a cycle-level behavioural model.
module tb_risc_phase_sequencer;
  localparam int OP_W = 4;
  localparam int TO_W = 4;
`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  risc_phase_sequencer_if #(.OP_W(OP_W)) bus();
  risc_phase_sequencer #(.OP_W(OP_W), .TO_W(TO_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int compared = 0;
  int mismatched = 0;
  int m_phase, m_op, m_stall;
  bit m_halt, m_zq, m_err, m_ill;
  // strobe vector order: {sel, rd, ld_ir, inc_pc, ld_pc, data_e, ld_ac, wr}
  function automatic logic [7:0] exp_strobes(input int ph, input int op, input bit zq, input bit h);
    bit alu, sto, jmp;
    alu = op >= 2 && op <= 5;
    sto = op == 6;
    jmp = op == 7;
    if (h) return 8'h00;
    case (ph)
      0: return 8'b1000_0000;
      1: return 8'b1100_0000;
      2, 3: return 8'b1110_0000;
      4: return (op == 0 || (TRAP && op >= 8)) ? 8'h00 : 8'b0001_0000;
      5: return {1'b0, alu, 6'b0};
      6: return {1'b0, alu, 1'b0, op == 1 && zq, jmp, sto, 2'b0};
      default: return {1'b0, alu, 2'b0, jmp, sto, alu, sto};
    endcase
  endfunction
  task automatic model_reset();
    m_phase = 0; m_op = 0; m_stall = 0;
    m_halt = 0; m_zq = 0; m_err = 0; m_ill = 0;
  endtask
  task automatic model_step();
    logic [7:0] s;
    bit trap;
    s = exp_strobes(m_phase, m_op, m_zq, m_halt);
    trap = TRAP && m_op >= 8;
    if (m_halt) begin
      if (bus.resume) begin
        m_halt = 0;
        m_phase = m_err ? 0 : 5;
        m_err = 0;
        m_ill = 0;
      end
    end else if (bus.en) begin
      if (m_phase == 4 && (m_op == 0 || trap)) begin
        m_halt = 1;
        m_ill = trap;
      end else if (!(s[6] || s[0]) || bus.mem_ready) begin
        if (m_phase == 3) m_op = int'(bus.opcode);
        if (m_phase == 5) m_zq = bus.zero;
        m_phase = (m_phase + 1) % 8;
        m_stall = 0;
      end else begin
        m_stall++;
        if (m_stall == 2 ** TO_W - 1) begin
          m_err = 1;
          m_halt = 1;
          m_stall = 0;
        end
      end
    end
  endtask
  task automatic check(input string tag);
    logic [7:0] s, e;
    s = {bus.sel, bus.rd, bus.ld_ir, bus.inc_pc, bus.ld_pc, bus.data_e, bus.ld_ac, bus.wr};
    e = exp_strobes(m_phase, m_op, m_zq, m_halt);
    compared++;
    assert (bus.phase === 3'(m_phase)) else begin
      mismatched++;
      $error("FAIL %s phase: observed %0d expected %0d", tag, bus.phase, m_phase);
    end
    compared++;
    assert (s === e) else begin
      mismatched++;
      $error("FAIL %s strobes: observed %b expected %b (phase %0d op %0d)", tag, s, e, m_phase, m_op);
    end
    compared++;
    assert ({bus.halt, bus.mem_err, bus.illegal} === {m_halt, m_err, m_ill}) else begin
      mismatched++;
      $error("FAIL %s halt/mem_err/illegal: observed %b expected %b", tag,
             {bus.halt, bus.mem_err, bus.illegal}, {m_halt, m_err, m_ill});
    end
  endtask
  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check(tag);
  endtask
  // Run until the phase wraps to 0 or the core halts; stall sn cycles in phase sp.
  task automatic run_instr(input int op, input bit z, input int sp, input int sn, input string tag);
    int k, n;
    k = 0;
    n = 0;
    bus.opcode = OP_W'(op);
    bus.zero = z;
    bus.en = 1'b1;
    bus.resume = 1'b0;
    do begin
      bus.mem_ready = !(m_phase == sp && k < sn);
      if (!bus.mem_ready) k++;
      cycle(tag);
      n++;
    end while (m_phase != 0 && !m_halt && n < 64);
    compared++;
    assert (n < 64) else begin
      mismatched++;
      $error("FAIL %s budget: observed %0d cycles expected < 64", tag, n);
    end
  endtask
  task automatic resume_pulse(input string tag);
    bus.resume = 1'b1;
    bus.en = 1'b1;
    cycle(tag);
    bus.resume = 1'b0;
  endtask
  initial begin
    bus.en = 1'b0;
    bus.opcode = '0;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b1;
    bus.resume = 1'b0;
    model_reset();
    #12;
    check("reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_instr(2, 0, -1, 0, "add");
    run_instr(1, 1, -1, 0, "skz_zero1");
    run_instr(1, 0, -1, 0, "skz_zero0");
    run_instr(6, 0, 7, 3, "sto_stall");
    run_instr(5, 0, 1, 100, "timeout");
    resume_pulse("timeout_resume");
    run_instr(3, 0, -1, 0, "after_timeout");
    run_instr(0, 0, -1, 0, "hlt");
    for (int i = 0; i < 20; i++) begin
      bus.en = 1'($urandom);
      bus.mem_ready = 1'($urandom);
      cycle("hlt_hold");
    end
    resume_pulse("hlt_resume");
    run_instr(4, 1, -1, 0, "hlt_finish");
    run_instr(9, 1, 6, 2, "op9");
    if (m_halt) resume_pulse("op9_resume");
    run_instr(2, 0, -1, 0, "op9_finish");
    bus.opcode = 4'd7;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 16 && m_phase != 6; i++) cycle("jmp");
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 400; i++) begin
      bus.en = $urandom_range(0, 3) != 0;
      bus.opcode = OP_W'($urandom_range(0, 15));
      bus.zero = 1'($urandom);
      bus.mem_ready = $urandom_range(0, 4) != 0;
      bus.resume = $urandom_range(0, 7) == 0;
      cycle("rand");
    end
    for (int i = 0; i < 300; i++) begin
      bus.en = $urandom_range(0, 7) != 0;
      bus.opcode = OP_W'($urandom_range(1, 7));
      bus.zero = 1'($urandom);
      bus.mem_ready = $urandom_range(0, 15) == 0;
      bus.resume = $urandom_range(0, 3) == 0;
      cycle("rand_stall");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
